// File: rtl/upsample_mc.sv
// upsample_mc
// Multi-channel interpolate-by-L front end for the CIC interpolator chain.
// Runs at the high rate under i_ena. Once per frame of L enabled cycles, at
// the selected phase slot, one sample per channel is taken from i_data. Every
// other slot is zero-stuffed, or held when zero-order hold is built in.
// L and phase are shadowed and only change at a frame wrap.
//
// Build option: define UPSAMPLE_MC_ZOH_EN to add zero-order hold (i_mode=1).
// Without it i_mode is ignored and only zero-stuffing exists.
module upsample_mc #(
  parameter int  gp_data_width  = 8,
  parameter int  gp_nr_channels = 2,
  parameter int  gp_max_factor  = 16,
  localparam int c_cnt_width    = $clog2(gp_max_factor),
  localparam int c_bus_width    = gp_nr_channels * gp_data_width
) (
  input  logic                   i_clk,
  input  logic                   i_rst_an,
  input  logic                   i_ena,
  input  logic [c_cnt_width:0]   i_factor,
  input  logic [c_cnt_width-1:0] i_phase,
  input  logic                   i_mode,
  input  logic                   i_valid,
  input  logic [c_bus_width-1:0] i_data,
  output logic                   o_ready,
  output logic [c_bus_width-1:0] o_data,
  output logic                   o_valid,
  output logic                   o_frame,
  output logic                   o_shift_done,
  output logic                   o_underrun
);

  localparam logic [c_cnt_width:0]   c_max_fac = (c_cnt_width+1)'(gp_max_factor);
  localparam logic [c_cnt_width:0]   c_fac_one = (c_cnt_width+1)'(1);
  localparam logic [c_cnt_width-1:0] c_cnt_one = c_cnt_width'(1);

  // Illegal factors: 0 runs as pass-through, anything too large saturates.
  function automatic logic [c_cnt_width:0] clamp_factor(input logic [c_cnt_width:0] fac);
    logic [c_cnt_width:0] res;
    res = fac;
    if (fac == '0) begin
      res = c_fac_one;
    end else if (fac > c_max_fac) begin
      res = c_max_fac;
    end
    return res;
  endfunction

  // A phase outside the frame is pulled back to the last slot of the frame.
  function automatic logic [c_cnt_width-1:0] clamp_phase(input logic [c_cnt_width-1:0] ph,
                                                         input logic [c_cnt_width:0]   fac);
    logic [c_cnt_width-1:0] res;
    res = ph;
    if ({1'b0, ph} >= fac) begin
      res = c_cnt_width'(fac - c_fac_one);
    end
    return res;
  endfunction

  logic [c_cnt_width-1:0] cnt_reg, cnt_next;
  logic [c_cnt_width:0]   fac_reg, fac_next;
  logic [c_cnt_width-1:0] ph_reg, ph_next;
  logic [c_bus_width-1:0] data_reg, data_next;
  logic                   valid_reg, valid_next;
  logic                   frame_reg, frame_next;
  logic                   done_reg, done_next;
  logic                   underrun_reg, underrun_next;
  logic                   loaded_reg, loaded_next;

  logic [c_cnt_width:0]   fac_new;
  logic [c_cnt_width-1:0] ph_new;
  logic                   load_slot;
  logic                   wrap;
  logic                   take;

  // Shadow candidates, sampled at reset and at every frame wrap.
  assign fac_new   = clamp_factor(i_factor);
  assign ph_new    = clamp_phase(i_phase, fac_new);

  assign load_slot = (cnt_reg == ph_reg);
  assign wrap      = ({1'b0, cnt_reg} == (fac_reg - c_fac_one));
  assign take      = i_ena & load_slot & i_valid;

  assign o_ready      = i_ena & load_slot;
  assign o_data       = data_reg;
  assign o_valid      = valid_reg;
  assign o_frame      = frame_reg;
  assign o_shift_done = done_reg;
  assign o_underrun   = underrun_reg;

`ifdef UPSAMPLE_MC_ZOH_EN
  logic [c_bus_width-1:0] hold_reg, hold_next;
  logic                   hold_mode;
  assign hold_mode = i_mode;
`else
  logic mode_unused;
  assign mode_unused = i_mode;
`endif

  // Per-channel output datapath; all channels follow the shared slot counter.
  genvar gi;
  generate
    for (gi = 0; gi < gp_nr_channels; gi++) begin : g_ch
      logic [gp_data_width-1:0] in_ch;
      logic [gp_data_width-1:0] cur_ch;
      logic [gp_data_width-1:0] fill_ch;

      assign in_ch  = i_data[gi*gp_data_width +: gp_data_width];
      assign cur_ch = data_reg[gi*gp_data_width +: gp_data_width];

`ifdef UPSAMPLE_MC_ZOH_EN
      // Non-load slots (including underrun slots) repeat the last taken sample in hold mode.
      assign fill_ch = hold_mode ? hold_reg[gi*gp_data_width +: gp_data_width] : '0;
      assign hold_next[gi*gp_data_width +: gp_data_width] =
        take ? in_ch : hold_reg[gi*gp_data_width +: gp_data_width];
`else
      assign fill_ch = '0;
`endif

      assign data_next[gi*gp_data_width +: gp_data_width] =
        !i_ena ? cur_ch : (take ? in_ch : fill_ch);
    end
  endgenerate

  // Slot counter, shadow reload and status flag next-state.
  always_comb begin
    cnt_next      = cnt_reg;
    fac_next      = fac_reg;
    ph_next       = ph_reg;
    loaded_next   = loaded_reg;
    done_next     = done_reg;
    underrun_next = underrun_reg;
    valid_next    = i_ena;
    frame_next    = i_ena & (cnt_reg == '0);
    if (i_ena) begin
      if (wrap) begin
        cnt_next = '0;
        fac_next = fac_new;
        ph_next  = ph_new;
      end else begin
        cnt_next = cnt_reg + c_cnt_one;
      end
      if (load_slot) begin
        loaded_next = 1'b1;
        if (!i_valid) begin
          underrun_next = 1'b1;
        end
      end
      // A frame counts as emitted once it has passed its load slot.
      if (wrap && (loaded_reg || load_slot)) begin
        done_next = 1'b1;
      end
    end
  end

  // State registers; reset captures the requested L and phase directly.
  always_ff @(posedge i_clk) begin
    if (!i_rst_an) begin
      cnt_reg      <= '0;
      fac_reg      <= fac_new;
      ph_reg       <= ph_new;
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      frame_reg    <= 1'b0;
      done_reg     <= 1'b0;
      underrun_reg <= 1'b0;
      loaded_reg   <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      fac_reg      <= fac_next;
      ph_reg       <= ph_next;
      data_reg     <= data_next;
      valid_reg    <= valid_next;
      frame_reg    <= frame_next;
      done_reg     <= done_next;
      underrun_reg <= underrun_next;
      loaded_reg   <= loaded_next;
    end
  end

`ifdef UPSAMPLE_MC_ZOH_EN
  // Last accepted sample, used as the fill value in hold mode.
  always_ff @(posedge i_clk) begin
    if (!i_rst_an) begin
      hold_reg <= '0;
    end else begin
      hold_reg <= hold_next;
    end
  end
`endif

endmodule

// File: tb/tb_upsample_mc.sv
// tb_upsample_mc
// Directed self-checking bench for upsample_mc (L=1..16, 2 x 8-bit channels).
// Expected values follow UPSAMPLE_MC_ZOH_EN when the bench is built with it.
module tb_upsample_mc;

  logic        i_clk = 1'b0;
  logic        i_rst_an = 1'b0;
  logic        i_ena = 1'b0;
  logic [4:0]  i_factor = 5'd4;
  logic [3:0]  i_phase = 4'd0;
  logic        i_mode = 1'b0;
  logic        i_valid = 1'b0;
  logic [15:0] i_data = 16'h0;
  logic        o_ready;
  logic [15:0] o_data;
  logic        o_valid;
  logic        o_frame;
  logic        o_shift_done;
  logic        o_underrun;

  int total = 0;
  int bad = 0;

  always #5 i_clk = ~i_clk;

  upsample_mc #(
    .gp_data_width (8),
    .gp_nr_channels(2),
    .gp_max_factor (16)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_an    (i_rst_an),
    .i_ena       (i_ena),
    .i_factor    (i_factor),
    .i_phase     (i_phase),
    .i_mode      (i_mode),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_ready     (o_ready),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame     (o_frame),
    .o_shift_done(o_shift_done),
    .o_underrun  (o_underrun)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_reset(input logic [4:0] fac, input logic [3:0] ph);
    i_rst_an = 1'b0;
    i_factor = fac;
    i_phase  = ph;
    tick();
    i_rst_an = 1'b1;
  endtask

  task automatic show(input string name, input int k);
    $display("%s k=%0d rdy=%b data=%h vld=%b frm=%b done=%b und=%b",
             name, k, o_ready, o_data, o_valid, o_frame, o_shift_done, o_underrun);
  endtask

  task automatic test_reset();
    i_ena = 1'b1; i_valid = 1'b1; i_data = 16'hFFFF; i_mode = 1'b0;
    apply_reset(5'd4, 4'd0);
    show("reset", 0);
    total++; if (o_data !== 16'h0) begin bad++; $display("FAIL reset_data got=%h want=0000", o_data); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_valid); end
    total++; if (o_frame !== 1'b0) begin bad++; $display("FAIL reset_frame got=%b want=0", o_frame); end
    total++; if (o_shift_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", o_shift_done); end
    total++; if (o_underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b want=0", o_underrun); end
    #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", o_ready); end
  endtask

  // L=4, phase 0, ch0=5 ch1=-3
  task automatic test_zero_stuff();
    logic [15:0] exp_d;
    i_ena = 1'b1; i_valid = 1'b1; i_data = 16'hFD05; i_mode = 1'b0;
    apply_reset(5'd4, 4'd0);
    for (int k = 0; k < 8; k++) begin
      #1;
      total++; if (o_ready !== (k % 4 == 0)) begin bad++; $display("FAIL zs_ready k=%0d got=%b want=%b", k, o_ready, (k % 4 == 0)); end
      tick();
      show("zero_stuff", k);
      exp_d = (k % 4 == 0) ? 16'hFD05 : 16'h0000;
      total++; if (o_data !== exp_d) begin bad++; $display("FAIL zs_data k=%0d got=%h want=%h", k, o_data, exp_d); end
      total++; if (o_frame !== (k % 4 == 0)) begin bad++; $display("FAIL zs_frame k=%0d got=%b want=%b", k, o_frame, (k % 4 == 0)); end
      total++; if (o_shift_done !== (k >= 3)) begin bad++; $display("FAIL zs_done k=%0d got=%b want=%b", k, o_shift_done, (k >= 3)); end
      total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL zs_valid k=%0d got=%b want=1", k, o_valid); end
    end
  endtask

  // L=4, phase 2
  task automatic test_phase();
    logic [15:0] exp_d;
    i_ena = 1'b1; i_valid = 1'b1; i_data = 16'hFD05; i_mode = 1'b0;
    apply_reset(5'd4, 4'd2);
    for (int k = 0; k < 8; k++) begin
      #1;
      total++; if (o_ready !== (k % 4 == 2)) begin bad++; $display("FAIL ph_ready k=%0d got=%b want=%b", k, o_ready, (k % 4 == 2)); end
      tick();
      show("phase", k);
      exp_d = (k % 4 == 2) ? 16'hFD05 : 16'h0000;
      total++; if (o_data !== exp_d) begin bad++; $display("FAIL ph_data k=%0d got=%h want=%h", k, o_data, exp_d); end
      total++; if (o_frame !== (k % 4 == 0)) begin bad++; $display("FAIL ph_frame k=%0d got=%b want=%b", k, o_frame, (k % 4 == 0)); end
      total++; if (o_shift_done !== (k >= 3)) begin bad++; $display("FAIL ph_done k=%0d got=%b want=%b", k, o_shift_done, (k >= 3)); end
    end
  endtask

  task automatic test_factor();
    logic [10:0] exp_frm;
    logic [15:0] exp_d;
    // 4 -> 3 mid-frame: frames start at k=0, 4, 7, 10
    exp_frm = 11'b10010010001;
    i_ena = 1'b1; i_valid = 1'b1; i_data = 16'h0102; i_mode = 1'b0;
    apply_reset(5'd4, 4'd0);
    for (int k = 0; k < 11; k++) begin
      if (k == 2) i_factor = 5'd3;
      tick();
      show("factor_chg", k);
      exp_d = exp_frm[k] ? 16'h0102 : 16'h0000;
      total++; if (o_frame !== exp_frm[k]) begin bad++; $display("FAIL fc_frame k=%0d got=%b want=%b", k, o_frame, exp_frm[k]); end
      total++; if (o_data !== exp_d) begin bad++; $display("FAIL fc_data k=%0d got=%h want=%h", k, o_data, exp_d); end
    end
    // factor 0 runs as pass-through
    apply_reset(5'd0, 4'd0);
    for (int k = 0; k < 3; k++) begin
      i_data = 16'h1111 * 16'(k + 1);
      #1;
      total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL f0_ready k=%0d got=%b want=1", k, o_ready); end
      tick();
      show("factor0", k);
      total++; if (o_data !== 16'h1111 * 16'(k + 1)) begin bad++; $display("FAIL f0_data k=%0d got=%h want=%h", k, o_data, 16'h1111 * 16'(k + 1)); end
      total++; if (o_frame !== 1'b1) begin bad++; $display("FAIL f0_frame k=%0d got=%b want=1", k, o_frame); end
      total++; if (o_shift_done !== 1'b1) begin bad++; $display("FAIL f0_done k=%0d got=%b want=1", k, o_shift_done); end
    end
    // factor 20 runs as 16
    i_data = 16'h0102;
    apply_reset(5'd20, 4'd0);
    for (int k = 0; k < 17; k++) begin
      tick();
      show("factor20", k);
      total++; if (o_frame !== (k == 0 || k == 16)) begin bad++; $display("FAIL f20_frame k=%0d got=%b want=%b", k, o_frame, (k == 0 || k == 16)); end
    end
    // phase 9 with L=3 runs as phase 2
    apply_reset(5'd3, 4'd9);
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (o_ready !== (k == 2)) begin bad++; $display("FAIL phclamp_ready k=%0d got=%b want=%b", k, o_ready, (k == 2)); end
      tick();
      show("phase_clamp", k);
    end
  endtask

  // L=2, phase 1, i_valid dropped on the second load slot
  task automatic test_underrun();
    logic [15:0] exp_d [0:5];
    exp_d = '{16'h0000, 16'h3344, 16'h0000, 16'h0000, 16'h0000, 16'h3344};
    i_ena = 1'b1; i_data = 16'h3344; i_mode = 1'b0;
    apply_reset(5'd2, 4'd1);
    for (int k = 0; k < 6; k++) begin
      i_valid = (k != 3);
      tick();
      show("underrun", k);
      total++; if (o_data !== exp_d[k]) begin bad++; $display("FAIL ur_data k=%0d got=%h want=%h", k, o_data, exp_d[k]); end
      total++; if (o_underrun !== (k >= 3)) begin bad++; $display("FAIL ur_flag k=%0d got=%b want=%b", k, o_underrun, (k >= 3)); end
    end
  endtask

  task automatic test_enable();
    logic [15:0] exp_d [0:8];
    logic [8:0]  exp_frm;
    exp_d   = '{16'h0A0B, 16'h0A0B, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0A0B};
    exp_frm = 9'b100000001;
    i_valid = 1'b1; i_data = 16'h0A0B; i_mode = 1'b0; i_ena = 1'b1;
    apply_reset(5'd4, 4'd0);
    for (int k = 0; k < 9; k++) begin
      i_ena = (k % 2 == 0);
      #1;
      total++; if (o_ready !== (k == 0 || k == 8)) begin bad++; $display("FAIL en_ready k=%0d got=%b want=%b", k, o_ready, (k == 0 || k == 8)); end
      tick();
      show("enable", k);
      total++; if (o_data !== exp_d[k]) begin bad++; $display("FAIL en_data k=%0d got=%h want=%h", k, o_data, exp_d[k]); end
      total++; if (o_valid !== (k % 2 == 0)) begin bad++; $display("FAIL en_valid k=%0d got=%b want=%b", k, o_valid, (k % 2 == 0)); end
      total++; if (o_frame !== exp_frm[k]) begin bad++; $display("FAIL en_frame k=%0d got=%b want=%b", k, o_frame, exp_frm[k]); end
    end
    // drive every output high, then reset mid-stream
    i_ena = 1'b1;
    apply_reset(5'd1, 4'd0);
    for (int k = 0; k < 3; k++) begin
      i_valid = (k != 1);
      tick();
      show("pre_reset", k);
    end
    total++; if ({o_data, o_valid, o_frame, o_shift_done, o_underrun} !== {16'h0A0B, 4'b1111}) begin
      bad++; $display("FAIL prerst_outs got=%h %b%b%b%b want=0a0b 1111", o_data, o_valid, o_frame, o_shift_done, o_underrun);
    end
    i_rst_an = 1'b0; i_factor = 5'd4;
    tick();
    i_rst_an = 1'b1;
    show("mid_reset", 0);
    total++; if (o_data !== 16'h0) begin bad++; $display("FAIL midrst_data got=%h want=0000", o_data); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", o_valid); end
    total++; if (o_frame !== 1'b0) begin bad++; $display("FAIL midrst_frame got=%b want=0", o_frame); end
    total++; if (o_shift_done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", o_shift_done); end
    total++; if (o_underrun !== 1'b0) begin bad++; $display("FAIL midrst_underrun got=%b want=0", o_underrun); end
    // two slots into an L=4 frame, reset again: counter must restart at slot 0
    tick();
    tick();
    i_rst_an = 1'b0;
    tick();
    i_rst_an = 1'b1;
    #1;
    show("restart", 0);
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL restart_ready got=%b want=1", o_ready); end
  endtask

  // L=3, phase 0, mode 1, inputs 7 then 9, then an underrun slot
  task automatic test_hold();
    logic [15:0] exp_d [0:6];
`ifdef UPSAMPLE_MC_ZOH_EN
    exp_d = '{16'h0707, 16'h0707, 16'h0707, 16'h0909, 16'h0909, 16'h0909, 16'h0909};
`else
    exp_d = '{16'h0707, 16'h0000, 16'h0000, 16'h0909, 16'h0000, 16'h0000, 16'h0000};
`endif
    i_ena = 1'b1; i_valid = 1'b1; i_mode = 1'b1;
    apply_reset(5'd3, 4'd0);
    for (int k = 0; k < 7; k++) begin
      i_data  = (k < 3) ? 16'h0707 : ((k < 6) ? 16'h0909 : 16'h0505);
      i_valid = (k != 6);
      tick();
      show("hold", k);
      total++; if (o_data !== exp_d[k]) begin bad++; $display("FAIL hold_data k=%0d got=%h want=%h", k, o_data, exp_d[k]); end
    end
    i_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_stuff();
    test_phase();
    test_factor();
    test_underrun();
    test_enable();
    test_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
